// File: rtl/svx32_mem_arbiter.sv
// Round-robin arbiter sharing the svx32_core data-memory port between two masters.
// Optional watchdog abort is compiled in with `define SVX32_ARB_TIMEOUT_EN.
module svx32_mem_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            pil_clk,
    input  logic            pil_rst_n,

    input  logic            pil_m0_req,
    input  logic            pil_m0_wen,
    input  logic [AW-1:0]   piv_m0_addr,
    input  logic [DW-1:0]   piv_m0_wdata,
    input  logic [DW/8-1:0] piv_m0_byte_sel,
    output logic            pol_m0_ack,
    output logic            pol_m0_valid,
    output logic [DW-1:0]   pov_m0_rdata,
    output logic            pol_m0_err,

    input  logic            pil_m1_req,
    input  logic            pil_m1_wen,
    input  logic [AW-1:0]   piv_m1_addr,
    input  logic [DW-1:0]   piv_m1_wdata,
    input  logic [DW/8-1:0] piv_m1_byte_sel,
    output logic            pol_m1_ack,
    output logic            pol_m1_valid,
    output logic [DW-1:0]   pov_m1_rdata,
    output logic            pol_m1_err,

    output logic            pol_mem_req,
    output logic            pol_mem_wen,
    output logic [AW-1:0]   pov_mem_addr,
    output logic [DW-1:0]   pov_mem_wdata,
    output logic [DW/8-1:0] pov_mem_byte_sel,
    input  logic            pil_mem_ack,
    input  logic            pil_mem_valid,
    input  logic [DW-1:0]   piv_mem_rdata,

    output logic            pov_grant
);

    localparam int BW = DW / 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT_RD = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;
    logic          grant_q, grant_d;
    logic          wen_q, wen_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [BW-1:0] bsel_q, bsel_d;

    logic          win;
    logic          ack_w;
    logic          valid_w;
    logic          err_w;
    logic          expire;

`ifdef SVX32_ARB_TIMEOUT_EN
    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Held at zero in IDLE so it starts from zero on every entry to ISSUE.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expire = (state_q != ST_IDLE) && (cnt_q >= CNT_LAST);

    always_ff @(posedge pil_clk or negedge pil_rst_n) begin
        if (!pil_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign expire         = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES > 1);
`endif

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        wen_d       = wen_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        bsel_d      = bsel_q;
        win         = 1'b0;
        ack_w       = 1'b0;
        valid_w     = 1'b0;
        err_w       = 1'b0;
        pol_mem_req = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A tie goes to whichever master was not served last.
                win = (pil_m0_req && pil_m1_req) ? ~last_q : pil_m1_req;
                if (pil_m0_req || pil_m1_req) begin
                    grant_d = win;
                    last_d  = win;
                    wen_d   = win ? pil_m1_wen      : pil_m0_wen;
                    addr_d  = win ? piv_m1_addr     : piv_m0_addr;
                    wdata_d = win ? piv_m1_wdata    : piv_m0_wdata;
                    bsel_d  = win ? piv_m1_byte_sel : piv_m0_byte_sel;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                pol_mem_req = 1'b1;
                if (pil_mem_ack) begin
                    ack_w = 1'b1;
                    if (wen_q) begin
                        state_d = ST_IDLE;
                    end else if (pil_mem_valid) begin
                        valid_w = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_RD;
                    end
                end else if (expire) begin
                    err_w   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_RD: begin
                if (pil_mem_valid) begin
                    valid_w = 1'b1;
                    state_d = ST_IDLE;
                end else if (expire) begin
                    err_w   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pil_clk or negedge pil_rst_n) begin
        if (!pil_rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            grant_q <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            bsel_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            bsel_q  <= bsel_d;
        end
    end

    assign pol_mem_wen      = wen_q;
    assign pov_mem_addr     = addr_q;
    assign pov_mem_wdata    = wdata_q;
    assign pov_mem_byte_sel = bsel_q;
    assign pov_grant        = grant_q;

    // Strobes and read data are steered only to the owning master.
    assign pol_m0_ack   = ack_w   & ~grant_q;
    assign pol_m1_ack   = ack_w   &  grant_q;
    assign pol_m0_valid = valid_w & ~grant_q;
    assign pol_m1_valid = valid_w &  grant_q;
    assign pol_m0_err   = err_w   & ~grant_q;
    assign pol_m1_err   = err_w   &  grant_q;
    assign pov_m0_rdata = pol_m0_valid ? piv_mem_rdata : '0;
    assign pov_m1_rdata = pol_m1_valid ? piv_mem_rdata : '0;

endmodule

// File: tb/tb_svx32_mem_arbiter.sv
// Scoreboard testbench for svx32_mem_arbiter: expected downstream issues and
// read returns are queued as stimulus is driven and retired by a negedge monitor.
module tb_svx32_mem_arbiter;

   typedef struct {
      logic        master;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  bsel;
   } issueT;

   typedef struct {
      logic        master;
      logic [31:0] data;
   } readT;

   logic        clk;
   logic        rstN;
   logic        m0Req, m0Wen, m1Req, m1Wen;
   logic [31:0] m0Addr, m0Wdata, m1Addr, m1Wdata;
   logic [3:0]  m0Bsel, m1Bsel;
   logic        m0Ack, m0Valid, m0Err, m1Ack, m1Valid, m1Err;
   logic [31:0] m0Rdata, m1Rdata;
   logic        memReq, memWen, memAck, memValid;
   logic [31:0] memAddr, memWdata, memRdata;
   logic [3:0]  memBsel;
   logic        grant;

   issueT       issueQ[$];
   readT        readQ[$];
   int          checks;
   int          failures;

   svx32_mem_arbiter #(
      .AW(32),
      .DW(32),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .pil_clk(clk),
      .pil_rst_n(rstN),
      .pil_m0_req(m0Req),
      .pil_m0_wen(m0Wen),
      .piv_m0_addr(m0Addr),
      .piv_m0_wdata(m0Wdata),
      .piv_m0_byte_sel(m0Bsel),
      .pol_m0_ack(m0Ack),
      .pol_m0_valid(m0Valid),
      .pov_m0_rdata(m0Rdata),
      .pol_m0_err(m0Err),
      .pil_m1_req(m1Req),
      .pil_m1_wen(m1Wen),
      .piv_m1_addr(m1Addr),
      .piv_m1_wdata(m1Wdata),
      .piv_m1_byte_sel(m1Bsel),
      .pol_m1_ack(m1Ack),
      .pol_m1_valid(m1Valid),
      .pov_m1_rdata(m1Rdata),
      .pol_m1_err(m1Err),
      .pol_mem_req(memReq),
      .pol_mem_wen(memWen),
      .pov_mem_addr(memAddr),
      .pov_mem_wdata(memWdata),
      .pov_mem_byte_sel(memBsel),
      .pil_mem_ack(memAck),
      .pil_mem_valid(memValid),
      .piv_mem_rdata(memRdata),
      .pov_grant(grant)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #50000;
      $display("[TB] FAIL watchdog: got no completion, expected finish before 50000 ns");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point; every check counts here and reports on mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Advance to just after the next rising edge, where inputs are driven.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one master's request fields and optionally queue the issue it should produce.
   task automatic applyStimulus(input logic master, input logic wen, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] bsel, input bit expectIssue);
      issueT e;
      if (master) begin
         m1Req = 1'b1; m1Wen = wen; m1Addr = addr; m1Wdata = wdata; m1Bsel = bsel;
      end else begin
         m0Req = 1'b1; m0Wen = wen; m0Addr = addr; m0Wdata = wdata; m0Bsel = bsel;
      end
      e = '{master: master, wen: wen, addr: addr, wdata: wdata, bsel: bsel};
      if (expectIssue) issueQ.push_back(e);
   endtask

   // Queue a read return and drive it on the downstream data strobe.
   task automatic driveReadData(input logic master, input logic [31:0] data);
      readT r;
      r = '{master: master, data: data};
      readQ.push_back(r);
      memValid = 1'b1;
      memRdata = data;
   endtask

   task automatic clearInputs();
      m0Req = 1'b0; m0Wen = 1'b0; m0Addr = '0; m0Wdata = '0; m0Bsel = '0;
      m1Req = 1'b0; m1Wen = 1'b0; m1Addr = '0; m1Wdata = '0; m1Bsel = '0;
      memAck = 1'b0; memValid = 1'b0; memRdata = '0;
   endtask

   task automatic resetDut();
      rstN = 1'b0;
      clearInputs();
      tick();
      tick();
      rstN = 1'b1;
   endtask

   task automatic checkDrained(input string tag);
      checkOutput({tag, "_issues_left"}, issueQ.size(), 0);
      checkOutput({tag, "_reads_left"}, readQ.size(), 0);
   endtask

   // Every accepted downstream request must match the oldest queued issue.
   always @(negedge clk) begin : issueMonitor
      issueT e;
      if (rstN && memReq && memAck) begin
         if (issueQ.size() == 0) begin
            checkOutput("unexpected_issue", 1, 0);
         end else begin
            e = issueQ.pop_front();
            checkOutput("issue_grant", grant, e.master);
            checkOutput("issue_wen", memWen, e.wen);
            checkOutput("issue_addr", memAddr, e.addr);
            checkOutput("issue_wdata", memWdata, e.wdata);
            checkOutput("issue_bsel", memBsel, e.bsel);
            checkOutput("issue_m0_ack", m0Ack, !e.master);
            checkOutput("issue_m1_ack", m1Ack, e.master);
         end
      end else if (m0Ack || m1Ack) begin
         checkOutput("stray_ack", {m0Ack, m1Ack}, 0);
      end
   end

   // Every read-valid pulse must match the oldest queued read return.
   always @(negedge clk) begin : readMonitor
      readT r;
      if (m0Valid || m1Valid) begin
         if (readQ.size() == 0) begin
            checkOutput("stray_valid", {m0Valid, m1Valid}, 0);
         end else begin
            r = readQ.pop_front();
            checkOutput("read_m0_valid", m0Valid, !r.master);
            checkOutput("read_m1_valid", m1Valid, r.master);
            checkOutput("read_rdata", r.master ? m1Rdata : m0Rdata, r.data);
            checkOutput("read_loser_rdata", r.master ? m0Rdata : m1Rdata, 0);
         end
      end
`ifndef SVX32_ARB_TIMEOUT_EN
      if (m0Err || m1Err) checkOutput("err_tied_low", {m0Err, m1Err}, 0);
`endif
   end

   // Directed sequence; each section documents its cycle plan inline with the drives.
   initial begin
      checks   = 0;
      failures = 0;
      clearInputs();
      rstN = 1'b1;
      #1 rstN = 1'b0;
      #2;
      checkOutput("rst_mem_req", memReq, 0);
      checkOutput("rst_mem_wen", memWen, 0);
      checkOutput("rst_mem_addr", memAddr, 0);
      checkOutput("rst_mem_wdata", memWdata, 0);
      checkOutput("rst_mem_bsel", memBsel, 0);
      checkOutput("rst_grant", grant, 0);
      checkOutput("rst_m_strobes", {m0Ack, m0Valid, m0Err, m1Ack, m1Valid, m1Err}, 0);
      checkOutput("rst_m_rdata", {m0Rdata, m1Rdata}, 0);
      @(posedge clk);
      #1 rstN = 1'b1;

      // Master 0 read: grant, ack one cycle later, data two cycles after ack.
      applyStimulus(1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 1'b1);
      @(negedge clk);
      checkOutput("m0rd_idle_no_req", memReq, 0);
      tick();
      memAck = 1'b1;
      @(negedge clk);
      checkOutput("m0rd_req_latency", memReq, 1);
      tick();
      memAck = 1'b0;
      m0Req  = 1'b0;
      @(negedge clk);
      checkOutput("m0rd_waitrd_no_req", memReq, 0);
      checkOutput("m0rd_waitrd_no_valid", m0Valid, 0);
      tick();
      driveReadData(1'b0, 32'hDEADBEEF);
      @(negedge clk);
      checkOutput("m0rd_m1_quiet", {m1Ack, m1Valid, m1Err, m1Rdata}, 0);
      tick();
      memValid = 1'b0;
      memRdata = '0;
      checkDrained("m0rd");

      // Master 1 write with immediate ack, then the FSM must be idle.
      applyStimulus(1'b1, 1'b1, 32'h200, 32'h12345678, 4'hF, 1'b1);
      tick();
      memAck = 1'b1;
      @(negedge clk);
      checkOutput("m1wr_mem_wen", memWen, 1);
      tick();
      memAck = 1'b0;
      m1Req  = 1'b0;
      @(negedge clk);
      checkOutput("m1wr_back_idle", memReq, 0);
      checkDrained("m1wr");

      // Same-cycle read completion skips WAIT_RD, so a request in the next cycle is granted at once.
      tick();
      applyStimulus(1'b0, 1'b0, 32'h300, 32'h0, 4'hF, 1'b1);
      tick();
      memAck = 1'b1;
      driveReadData(1'b0, 32'hCAFEF00D);
      tick();
      memAck   = 1'b0;
      memValid = 1'b0;
      m0Req    = 1'b0;
      applyStimulus(1'b1, 1'b0, 32'h340, 32'h0, 4'h3, 1'b1);
      @(negedge clk);
      checkOutput("sc_idle_after_complete", memReq, 0);
      tick();
      memAck = 1'b1;
      @(negedge clk);
      checkOutput("sc_next_grant", memReq, 1);
      tick();
      memAck = 1'b0;
      m1Req  = 1'b0;
      driveReadData(1'b1, 32'h0BADF00D);
      tick();
      memValid = 1'b0;
      checkDrained("samecycle");

      // Round-robin: both masters write continuously with instant acks; grants alternate from m0.
      resetDut();
      applyStimulus(1'b0, 1'b1, 32'h10, 32'hA0A0A0A0, 4'hF, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h20, 32'hB1B1B1B1, 4'hC, 1'b0);
      for (int i = 0; i < 4; i++) begin
         issueQ.push_back('{master: 1'b0, wen: 1'b1, addr: 32'h10, wdata: 32'hA0A0A0A0, bsel: 4'hF});
         issueQ.push_back('{master: 1'b1, wen: 1'b1, addr: 32'h20, wdata: 32'hB1B1B1B1, bsel: 4'hC});
      end
      memAck = 1'b1;
      repeat (16) tick();
      m0Req  = 1'b0;
      m1Req  = 1'b0;
      memAck = 1'b0;
      @(negedge clk);
      checkOutput("rr_idle_after_8", memReq, 0);
      checkDrained("rr");

      // Memory never acks master 0 while master 1 waits behind it.
      resetDut();
`ifdef SVX32_ARB_TIMEOUT_EN
      applyStimulus(1'b0, 1'b0, 32'h500, 32'h0, 4'hF, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h600, 32'h55AA55AA, 4'h5, 1'b1);
      tick();
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         checkOutput("to_no_err_early", {m0Err, m1Err}, 0);
         tick();
      end
      @(negedge clk);
      checkOutput("to_m0_err_pulse", m0Err, 1);
      checkOutput("to_m1_err_quiet", m1Err, 0);
      tick();
      m0Req = 1'b0;
      @(negedge clk);
      checkOutput("to_req_dropped", memReq, 0);
      checkOutput("to_err_one_cycle", m0Err, 0);
      tick();
      memAck = 1'b1;
      @(negedge clk);
      checkOutput("to_m1_granted", memReq, 1);
      tick();
      memAck = 1'b0;
      m1Req  = 1'b0;
`else
      applyStimulus(1'b0, 1'b0, 32'h500, 32'h0, 4'hF, 1'b1);
      applyStimulus(1'b1, 1'b1, 32'h600, 32'h55AA55AA, 4'h5, 1'b1);
      tick();
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         checkOutput("noto_req_held", memReq, 1);
         tick();
      end
      memAck = 1'b1;
      @(negedge clk);
      tick();
      memAck = 1'b0;
      m0Req  = 1'b0;
      driveReadData(1'b0, 32'h13579BDF);
      tick();
      memValid = 1'b0;
      @(negedge clk);
      checkOutput("noto_idle_between", memReq, 0);
      tick();
      memAck = 1'b1;
      @(negedge clk);
      checkOutput("noto_m1_granted", memReq, 1);
      tick();
      memAck = 1'b0;
      m1Req  = 1'b0;
`endif
      tick();
      checkDrained("timeout");

      // Reset asserted in WAIT_RD clears everything at once; a late valid is ignored.
      resetDut();
      applyStimulus(1'b0, 1'b0, 32'h400, 32'h0, 4'hF, 1'b1);
      tick();
      memAck = 1'b1;
      tick();
      memAck = 1'b0;
      m0Req  = 1'b0;
      #2 rstN = 1'b0;
      #1;
      checkOutput("rstmid_mem_req", memReq, 0);
      checkOutput("rstmid_mem_addr", memAddr, 0);
      checkOutput("rstmid_grant", grant, 0);
      checkOutput("rstmid_strobes", {m0Ack, m0Valid, m0Err, m1Ack, m1Valid, m1Err}, 0);
      tick();
      rstN     = 1'b1;
      memValid = 1'b1;
      memRdata = 32'hFFFF0000;
      @(negedge clk);
      checkOutput("rstmid_late_valid", {m0Valid, m1Valid}, 0);
      checkOutput("rstmid_late_rdata", m0Rdata, 0);
      tick();
      memValid = 1'b0;
      memRdata = '0;
      tick();
      checkDrained("rstmid");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
